regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the RISC_TOY core.
- Generalises the fixed 2-read/1-write REGFILE to NRP read ports, with an optional hard-zero r0.
- Adds a per-entry pending-write scoreboard and outstanding-write counter so the decode stage can stall on RAW hazards from multi-cycle producers (loads).
- Sits between decode (read/issue side) and writeback (write side).

Parameters:
- AW, 5, address width.
- ENTRY, 32, number of registers; legal range 2..2**AW.
- DW, 32, data width.
- NRP, 2, number of read ports; legal range 1..4.
- ZERO_R0, 0, when 1: entry 0 always reads 0, ignores writes and is never pending.
- MAXPEND, 4, maximum simultaneously pending entries; legal range 1..ENTRY.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- WEN  in  1  write enable.
- WA  in  AW  write address.
- DI  in  DW  write data.
- RA  in  NRP*AW  packed read addresses; port i uses bits [i*AW +: AW].
- RVLD  in  NRP  per-port "operand actually used"; gates hazard check only.
- DOUT  out  NRP*DW  packed read data.
- SEN  in  1  mark a register pending (producer issued).
- SA  in  AW  address to mark.
- BUSY  out  NRP  per-port hazard flag.
- STALL  out  1  OR over i of (BUSY[i] & RVLD[i]).
- PFULL  out  1  pending count == MAXPEND.
- PCNT  out  $clog2(MAXPEND+1)  number of pending entries.

Behaviour:
- Reset (RSTN low, asynchronous, any time): all entries 0, all pending bits 0, PCNT 0, PFULL 0.
  - Reset mid-operation discards everything in flight.
  - Outputs are combinational, so DOUT reads 0 and BUSY/STALL are 0 while reset is held.
- Write: at posedge, if WEN and WA<ENTRY (and not (ZERO_R0 and WA==0)), entry[WA] <= DI. Out-of-range WA is ignored.
- Read: combinational, zero latency.
  - DOUT[i] = entry[RA[i]].
  - Out-of-range RA reads 0; with ZERO_R0, RA==0 reads 0.
  - Bypass: see Optional Feature.
- Scoreboard, evaluated at each posedge:
  - Set: SEN, SA valid, PFULL==0 and entry not pending -> pend[SA] <= 1; PCNT +1.
  - Set on an already-pending entry (WAW): pending stays 1, PCNT unchanged.
  - SEN while PFULL: ignored, no state change; the issuer must not assert it.
  - SEN on an invalid SA (out of range, or r0 with ZERO_R0): ignored.
  - Clear: WEN on a pending, valid WA -> pend[WA] <= 0; PCNT -1.
  - WEN on a non-pending entry writes data only.
  - Simultaneous set and clear, same index: set wins. Pending stays 1, PCNT unchanged (the newer producer owns the register).
  - Simultaneous set and clear, different indices: both apply; PCNT unchanged.
  - Simultaneous set while PFULL and a clear: the set is still ignored (PFULL is sampled pre-edge); PCNT -1.
  - PCNT never wraps; it saturates at 0 and at MAXPEND by construction.
- Hazard (combinational): BUSY[i] = pend[RA[i]] & ~(bypass hit on port i).
  - Bypass hit on port i = WEN & WA==RA[i] & bypass enabled.
  - RVLD does not affect BUSY, only STALL.
  - Invalid RA never asserts BUSY.
- PFULL = (PCNT == MAXPEND).

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: if WEN and WA==RA[i] (valid, non-zero-r0), then DOUT[i] = DI and BUSY[i] = 0 in the same cycle (write-through forwarding).
- Undefined: DOUT[i] returns the pre-write value, and BUSY[i] stays asserted during the write cycle; it drops in the cycle after the write edge (one extra stall cycle per hazard).

Test Plan:
- Reset/basic, ZERO_R0=0: after reset all 32 entries read 0 on both ports; write r5=0xDEADBEEF, next cycle RA0=5 -> DOUT0=0xDEADBEEF, RA1=6 -> 0.
- Bypass, macro defined: WEN=1, WA=7, DI=0x12345678, RA1=7 in the same cycle -> DOUT1=0x12345678. Macro undefined -> DOUT1=old value, and next cycle 0x12345678.
- Scoreboard RAW, macro defined: SEN, SA=3 -> PCNT=1. Next cycle RA0=3, RVLD=01 -> BUSY0=1, STALL=1. With RVLD=00 -> STALL=0, BUSY0=1. Write r3=0x55 -> same cycle BUSY0=0, DOUT0=0x55; after edge PCNT=0.
- Full/ignore, MAXPEND=4: SEN on r1,r2,r3,r4 -> PCNT=4, PFULL=1. SEN r9 -> pend[9]=0, PCNT=4. Write r2 -> PCNT=3, PFULL=0. SEN r1 again (WAW) -> PCNT=3.
- Simultaneous: SEN SA=8 with WEN WA=8 while r8 pending -> r8 updated, pend[8]=1, PCNT unchanged. SEN SA=10 with WEN WA=8 -> pend[10]=1, pend[8]=0, PCNT unchanged.
- ZERO_R0=1, NRP=3: write r0=0xFFFF -> all ports with RA=0 read 0. SEN SA=0 -> PCNT=0, BUSY=000. Assert RSTN low mid-sequence with PCNT=2 -> PCNT=0, all entries 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with NRP combinational read ports, optional hard-zero r0,
// and a pending-write scoreboard for RAW stalls. Optional macro: REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int AW      = 5,
    parameter int ENTRY   = 32,
    parameter int DW      = 32,
    parameter int NRP     = 2,
    parameter int ZERO_R0 = 0,
    parameter int MAXPEND = 4,
    localparam int CW     = $clog2(MAXPEND + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wen,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     di,
    input  logic [NRP*AW-1:0] ra,
    input  logic [NRP-1:0]    rvld,
    output logic [NRP*DW-1:0] dout,
    input  logic              sen,
    input  logic [AW-1:0]     sa,
    output logic [NRP-1:0]    busy,
    output logic              stall,
    output logic              pfull,
    output logic [CW-1:0]     pcnt
);

    logic [DW-1:0]    mem [ENTRY];
    logic [ENTRY-1:0] pend;
    logic [ENTRY-1:0] pendNext;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cntNext;
    logic             setReq;
    logic             setNew;
    logic             clrEff;

    // An address is usable only if it is in range and is not the hard-wired r0.
    function automatic logic isValid(input logic [AW-1:0] a);
        return (32'(a) < ENTRY) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRY; i++) mem[i] <= '0;
        end else if (wen && isValid(wa)) begin
            mem[wa] <= di;
        end
    end

    // A set on a register that is also being written this edge wins: the newer producer owns it.
    always_comb begin
        setReq   = sen && isValid(sa) && !pfull;
        setNew   = setReq && !pend[sa];
        clrEff   = wen && isValid(wa) && pend[wa] && !(setReq && (sa == wa));
        pendNext = pend;
        if (clrEff) pendNext[wa] = 1'b0;
        if (setReq) pendNext[sa] = 1'b1;
        cntNext = cnt;
        if (setNew && !clrEff)
            cntNext = cnt + 1'b1;
        else if (!setNew && clrEff)
            cntNext = cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pendNext;
            cnt  <= cntNext;
        end
    end

    always_comb begin
        dout = '0;
        busy = '0;
        for (int i = 0; i < NRP; i++) begin
            logic [AW-1:0] a;
            logic          hit;
            a = ra[i*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
            hit = wen && (wa == a) && isValid(a);
`else
            hit = 1'b0;
`endif
            if (isValid(a)) begin
                dout[i*DW +: DW] = hit ? di : mem[a];
                busy[i]          = pend[a] && !hit;
            end
        end
    end

    assign stall = |(busy & rvld);
    assign pfull = (cnt == CW'(MAXPEND));
    assign pcnt  = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a vector table on the default configuration plus
// hand-written sequences for hard-zero r0, three read ports and asynchronous reset.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstnA, rstnB;
    logic        wenA, senA;
    logic [4:0]  waA, saA;
    logic [31:0] diA;
    logic [9:0]  raA;
    logic [1:0]  rvldA, busyA;
    logic [63:0] doutA;
    logic        stallA, pfullA;
    logic [2:0]  pcntA;

    logic        wenB, senB;
    logic [4:0]  waB, saB;
    logic [31:0] diB;
    logic [14:0] raB;
    logic [2:0]  rvldB, busyB;
    logic [95:0] doutB;
    logic        stallB, pfullB;
    logic [2:0]  pcntB;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_sb dutA (
        .clk(clk), .rstn(rstnA), .wen(wenA), .wa(waA), .di(diA), .ra(raA), .rvld(rvldA),
        .dout(doutA), .sen(senA), .sa(saA), .busy(busyA), .stall(stallA), .pfull(pfullA),
        .pcnt(pcntA)
    );

    regfile_sb #(.AW(5), .ENTRY(32), .DW(32), .NRP(3), .ZERO_R0(1), .MAXPEND(4)) dutB (
        .clk(clk), .rstn(rstnB), .wen(wenB), .wa(waB), .di(diB), .ra(raB), .rvld(rvldB),
        .dout(doutB), .sen(senB), .sa(saB), .busy(busyB), .stall(stallB), .pfull(pfullB),
        .pcnt(pcntB)
    );

    typedef struct {
        bit          wen;
        bit [4:0]    wa;
        logic [31:0] di;
        bit [4:0]    ra0;
        bit [4:0]    ra1;
        bit [1:0]    rvld;
        bit          sen;
        bit [4:0]    sa;
        logic [31:0] expD0;
        logic [31:0] expD1;
        bit [1:0]    expBusy;
        bit          expStall;
        bit [2:0]    expPcnt;
        bit          expPfull;
    } vec_t;

    vec_t vecs[28];

    task automatic checkOutput(input string nm, input logic [95:0] act, input logic [95:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wenA  = v.wen;
        waA   = v.wa;
        diA   = v.di;
        raA   = {v.ra1, v.ra0};
        rvldA = v.rvld;
        senA  = v.sen;
        saA   = v.sa;
    endtask

    initial begin
        // wen wa di ra0 ra1 rvld sen sa | d0 d1 busy stall pcnt pfull
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 5, 6, 2'b00, 0, 0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00, 0, 0, 0};
        vecs[1]  = '{0, 0, 32'h0, 5, 6, 2'b00, 0, 0, 32'hDEADBEEF, 32'h0, 2'b00, 0, 0, 0};
        vecs[2]  = '{1, 7, 32'hAAAA0000, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0};
        vecs[3]  = '{1, 7, 32'h12345678, 5, 7, 2'b00, 0, 0, 32'hDEADBEEF, BYP ? 32'h12345678 : 32'hAAAA0000, 2'b00, 0, 0, 0};
        vecs[4]  = '{0, 0, 32'h0, 0, 7, 2'b00, 0, 0, 32'h0, 32'h12345678, 2'b00, 0, 0, 0};
        vecs[5]  = '{0, 0, 32'h0, 3, 0, 2'b01, 1, 3, 32'h0, 32'h0, 2'b00, 0, 0, 0};
        vecs[6]  = '{0, 0, 32'h0, 3, 0, 2'b01, 0, 0, 32'h0, 32'h0, 2'b01, 1, 1, 0};
        vecs[7]  = '{0, 0, 32'h0, 3, 0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b01, 0, 1, 0};
        vecs[8]  = '{1, 3, 32'h55, 3, 0, 2'b01, 0, 0, BYP ? 32'h55 : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01, !BYP, 1, 0};
        vecs[9]  = '{0, 0, 32'h0, 3, 0, 2'b01, 0, 0, 32'h55, 32'h0, 2'b00, 0, 0, 0};
        vecs[10] = '{0, 0, 32'h0, 0, 0, 2'b00, 1, 1, 32'h0, 32'h0, 2'b00, 0, 0, 0};
        vecs[11] = '{0, 0, 32'h0, 0, 0, 2'b00, 1, 2, 32'h0, 32'h0, 2'b00, 0, 1, 0};
        vecs[12] = '{0, 0, 32'h0, 0, 0, 2'b00, 1, 3, 32'h0, 32'h0, 2'b00, 0, 2, 0};
        vecs[13] = '{0, 0, 32'h0, 0, 0, 2'b00, 1, 4, 32'h0, 32'h0, 2'b00, 0, 3, 0};
        vecs[14] = '{0, 0, 32'h0, 9, 4, 2'b11, 1, 9, 32'h0, 32'h0, 2'b10, 1, 4, 1};
        vecs[15] = '{0, 0, 32'h0, 9, 2, 2'b00, 0, 0, 32'h0, 32'h0, 2'b10, 0, 4, 1};
        vecs[16] = '{1, 2, 32'h22, 2, 9, 2'b01, 0, 0, BYP ? 32'h22 : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01, !BYP, 4, 1};
        vecs[17] = '{0, 0, 32'h0, 2, 1, 2'b11, 1, 1, 32'h22, 32'h0, 2'b10, 1, 3, 0};
        vecs[18] = '{0, 0, 32'h0, 1, 0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b01, 0, 3, 0};
        vecs[19] = '{1, 4, 32'h44, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 0, 3, 0};
        vecs[20] = '{0, 0, 32'h0, 4, 0, 2'b00, 1, 8, 32'h44, 32'h0, 2'b00, 0, 2, 0};
        vecs[21] = '{1, 8, 32'h88, 8, 3, 2'b00, 1, 8, BYP ? 32'h88 : 32'h0, 32'h55, BYP ? 2'b10 : 2'b11, 0, 3, 0};
        vecs[22] = '{0, 0, 32'h0, 8, 10, 2'b00, 0, 0, 32'h88, 32'h0, 2'b01, 0, 3, 0};
        vecs[23] = '{1, 8, 32'h99, 10, 8, 2'b00, 1, 10, 32'h0, BYP ? 32'h99 : 32'h88, BYP ? 2'b00 : 2'b10, 0, 3, 0};
        vecs[24] = '{0, 0, 32'h0, 10, 8, 2'b11, 0, 0, 32'h0, 32'h99, 2'b01, 1, 3, 0};
        vecs[25] = '{0, 0, 32'h0, 0, 0, 2'b00, 1, 12, 32'h0, 32'h0, 2'b00, 0, 3, 0};
        vecs[26] = '{1, 12, 32'hC, 13, 12, 2'b00, 1, 13, 32'h0, BYP ? 32'hC : 32'h0, BYP ? 2'b00 : 2'b10, 0, 4, 1};
        vecs[27] = '{0, 0, 32'h0, 13, 12, 2'b11, 0, 0, 32'h0, 32'hC, 2'b00, 0, 3, 0};

        rstnA = 1'b0; rstnB = 1'b0;
        wenA = 0; waA = 0; diA = 0; raA = 0; rvldA = 0; senA = 0; saA = 0;
        wenB = 0; waB = 0; diB = 0; raB = 0; rvldB = 0; senB = 0; saB = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstHoldPcnt", 96'(pcntA), 96'd0);
        rstnA = 1'b1; rstnB = 1'b1;

        // Every entry of the default instance must read zero after reset.
        for (int i = 0; i < 32; i++) begin
            raA = {5'(31 - i), 5'(i)};
            #1;
            checkOutput($sformatf("rst.r%0d", i), 96'(doutA), 96'd0);
        end
        @(negedge clk);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("v%0d.d0", i), 96'(doutA[31:0]), 96'(vecs[i].expD0));
            checkOutput($sformatf("v%0d.d1", i), 96'(doutA[63:32]), 96'(vecs[i].expD1));
            checkOutput($sformatf("v%0d.busy", i), 96'(busyA), 96'(vecs[i].expBusy));
            checkOutput($sformatf("v%0d.stall", i), 96'(stallA), 96'(vecs[i].expStall));
            checkOutput($sformatf("v%0d.pcnt", i), 96'(pcntA), 96'(vecs[i].expPcnt));
            checkOutput($sformatf("v%0d.pfull", i), 96'(pfullA), 96'(vecs[i].expPfull));
        end
        @(negedge clk);
        applyStimulus('{0, 0, 32'h0, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0});

        // Hard-zero r0 on the three-port instance: writes and marks to r0 are dropped.
        wenB = 1; waB = 0; diB = 32'hFFFF; raB = 15'd0;
        #2;
        checkOutput("b.r0SameCycle", doutB, 96'd0);
        @(negedge clk);
        wenB = 0; senB = 1; saB = 0;
        #2;
        checkOutput("b.r0AfterWrite", doutB, 96'd0);
        @(negedge clk);
        senB = 0;
        #2;
        checkOutput("b.r0Pcnt", 96'(pcntB), 96'd0);
        checkOutput("b.r0Busy", 96'(busyB), 96'd0);
        wenB = 1; waB = 5; diB = 32'hABCD;
        @(negedge clk);
        wenB = 0; senB = 1; saB = 5;
        @(negedge clk);
        saB = 6;
        @(negedge clk);
        senB = 0; raB = {5'd0, 5'd6, 5'd5}; rvldB = 3'b011;
        #2;
        checkOutput("b.prePcnt", 96'(pcntB), 96'd2);
        checkOutput("b.preBusy", 96'(busyB), 96'b011);
        checkOutput("b.preStall", 96'(stallB), 96'd1);
        checkOutput("b.preDout", doutB, {32'h0, 32'h0, 32'hABCD});

        // Reset lands between clock edges and must act immediately.
        #1 rstnB = 1'b0;
        #1;
        checkOutput("b.rstPcnt", 96'(pcntB), 96'd0);
        checkOutput("b.rstBusy", 96'(busyB), 96'd0);
        checkOutput("b.rstStall", 96'(stallB), 96'd0);
        checkOutput("b.rstDout", doutB, 96'd0);
        @(negedge clk);
        rstnB = 1'b1;
        #2;
        checkOutput("b.afterRstDout", doutB, 96'd0);
        checkOutput("b.afterRstPfull", 96'(pfullB), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
